// File: rtl/arbitro_rr_canales_if.sv
// arbitro_rr_canales_if: request/grant bundle between the requesters and the channel arbiter
interface arbitro_rr_canales_if;
   logic [7:0] req;
   logic       done;
   logic [3:0] sel;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;
   modport master (input req, done, output sel, gnt, busy, timeout);
   modport slave  (output req, done, input sel, gnt, busy, timeout);
endinterface

// File: rtl/arbitro_rr_canales.sv
// arbitro_rr_canales: round-robin arbiter for 8 channels with bounded hold and a dead cycle between owners
module arbitro_rr_canales #(
   parameter int HOLD_MAX  = 255,
   parameter int CODE_BASE = 3
) (
   input logic clk,
   input logic rst_n,
   arbitro_rr_canales_if.master io
);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t      state;
   logic [2:0]  owner;
   logic [2:0]  ptr;
   logic [2:0]  nxt;
   logic [15:0] hold_cnt;
   logic        at_limit;
   logic        rel;
   // first requester at or after ptr; the descending loop leaves the closest one
   always_comb begin
      nxt = ptr;
      for (int j = 7; j >= 0; j--)
         if (io.req[ptr + 3'(j)]) nxt = ptr + 3'(j);
   end
   always_comb begin
      at_limit = hold_cnt == 16'(HOLD_MAX - 1);
      rel      = io.done | ~io.req[owner] | at_limit;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         ptr        <= '0;
         hold_cnt   <= '0;
         io.sel     <= '0;
         io.gnt     <= '0;
         io.busy    <= 1'b0;
         io.timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               io.timeout <= 1'b0;
               if (|io.req) begin
                  state    <= GRANT;
                  owner    <= nxt;
                  hold_cnt <= '0;
                  io.sel   <= 4'(CODE_BASE) + {1'b0, nxt};
                  io.gnt   <= 8'b1 << nxt;
                  io.busy  <= 1'b1;
               end
            end
            GRANT: begin
               hold_cnt <= (hold_cnt == 16'(HOLD_MAX)) ? hold_cnt : hold_cnt + 16'd1;
               if (rel) begin
                  state      <= GAP;
                  ptr        <= owner + 3'd1;
                  io.sel     <= '0;
                  io.gnt     <= '0;
                  io.busy    <= 1'b0;
                  // a forced release only counts when the owner did not let go on its own
                  io.timeout <= ~io.done & io.req[owner];
               end
            end
            GAP: begin
               state      <= IDLE;
               io.timeout <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
